multi_synchro_filter: RTL and testbench

//  Next-generation single-bit resynchroniser: NCH independent async inputs brought into
//  the dstclk domain through an NSTAGES flop chain per channel. Each channel then passes

---
 rtl/multi_synchro_filter.sv | 88 ++++++++
 tb/tb_multi_synchro_filter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_synchro_filter.sv
// Multi-channel single-bit resynchroniser: per-channel flop chain into dstclk,
// programmable stability filter, and registered rise/fall pulse generation.
module multi_synchro_filter #(
    parameter int             NCH      = 4,
    parameter int             NSTAGES  = 2,
    parameter int             FILT_LEN = 0,
    parameter logic [NCH-1:0] RST_VAL  = '0
) (
    input  logic           dstclk,
    input  logic           dstresetn,
    input  logic [NCH-1:0] srcdata,
    output logic [NCH-1:0] dstdata,
    output logic [NCH-1:0] dstrise,
    output logic [NCH-1:0] dstfall,
    output logic [NCH-1:0] dstedge
);

    localparam int             L    = (FILT_LEN < 1) ? 1 : FILT_LEN;
    localparam int             CW   = (FILT_LEN <= 1) ? 1 : $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0]  TERM = CW'(L - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    // Chain flops are pure wires between stages so placement can keep them adjacent.
    (* async_reg = "true", dont_touch = "true" *)
    logic [NSTAGES-1:0][NCH-1:0] sync_q;
    logic [NSTAGES-1:0][NCH-1:0] sync_d;

    logic [NCH-1:0]              syn;
    logic [NCH-1:0][CW-1:0]      cnt_q;
    logic [NCH-1:0][CW-1:0]      cnt_d;
    logic [NCH-1:0]              data_q;
    logic [NCH-1:0]              data_d;
    logic [NCH-1:0]              prev_q;
    logic [NCH-1:0]              prev_d;

    always_comb begin
        sync_d[0] = srcdata;
        for (int k = 1; k < NSTAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign syn = sync_q[NSTAGES-1];

    // A single matching cycle restarts the count; the counter never passes TERM.
    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        prev_d = data_q;
        for (int i = 0; i < NCH; i++) begin
            if (syn[i] == data_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == TERM) begin
                data_d[i] = syn[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + ONE;
            end
        end
    end

    always_ff @(posedge dstclk or negedge dstresetn) begin
        if (!dstresetn) begin
            sync_q <= {NSTAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    always_ff @(posedge dstclk or negedge dstresetn) begin
        if (!dstresetn) begin
            cnt_q  <= '0;
            data_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
            prev_q <= prev_d;
        end
    end

    // prev_q resets to the same value as data_q, so no pulse right after reset.
    assign dstdata = data_q;
    assign dstrise = data_q & ~prev_q;
    assign dstfall = ~data_q & prev_q;
    assign dstedge = dstrise | dstfall;

endmodule

// File: tb/tb_multi_synchro_filter.sv
// Directed and randomised checks of multi_synchro_filter in three configurations.
`timescale 1ns/1ps
module tb_multi_synchro_filter;

    logic       clk;
    logic       rst_n;
    logic [3:0] src;

    logic [3:0] a_data, a_rise, a_fall, a_edge;
    logic [3:0] b_data, b_rise, b_fall, b_edge;
    logic [3:0] c_data, c_rise, c_fall, c_edge;

    int n_tests = 0;
    int n_fail  = 0;
    bit model_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    multi_synchro_filter #(.NCH(4), .NSTAGES(2), .FILT_LEN(0), .RST_VAL(4'b1010)) dut_a (
        .dstclk(clk), .dstresetn(rst_n), .srcdata(src),
        .dstdata(a_data), .dstrise(a_rise), .dstfall(a_fall), .dstedge(a_edge));

    multi_synchro_filter #(.NCH(4), .NSTAGES(3), .FILT_LEN(4), .RST_VAL(4'b0000)) dut_b (
        .dstclk(clk), .dstresetn(rst_n), .srcdata(src),
        .dstdata(b_data), .dstrise(b_rise), .dstfall(b_fall), .dstedge(b_edge));

    multi_synchro_filter #(.NCH(4), .NSTAGES(2), .FILT_LEN(8), .RST_VAL(4'b0000)) dut_c (
        .dstclk(clk), .dstresetn(rst_n), .srcdata(src),
        .dstdata(c_data), .dstrise(c_rise), .dstfall(c_fall), .dstedge(c_edge));

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model for the NSTAGES=2, FILT_LEN=8 instance.
    logic [3:0] m_s0, m_s1, m_data, m_prev;
    int         m_run [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s0   <= 4'b0000;
            m_s1   <= 4'b0000;
            m_data <= 4'b0000;
            m_prev <= 4'b0000;
            for (int i = 0; i < 4; i++) m_run[i] <= 0;
        end else begin
            m_s0   <= src;
            m_s1   <= m_s0;
            m_prev <= m_data;
            for (int i = 0; i < 4; i++) begin
                if (m_s1[i] == m_data[i]) begin
                    m_run[i] <= 0;
                end else if (m_run[i] + 1 >= 8) begin
                    m_data[i] <= m_s1[i];
                    m_run[i]  <= 0;
                end else begin
                    m_run[i] <= m_run[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_en) begin
            chk("c_model_data", c_data, m_data);
            chk("c_model_rise", c_rise, m_data & ~m_prev);
            chk("c_model_fall", c_fall, ~m_data & m_prev);
            chk("c_model_edge", c_edge, m_data ^ m_prev);
        end
    end

    typedef struct {
        logic [3:0] src;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    vec_t       vecs [8];
    logic [3:0] prev;
    logic [3:0] acc;

    initial begin
        vecs[0] = '{src: 4'b1011, rise: 4'b0001, fall: 4'b0000};
        vecs[1] = '{src: 4'b0010, rise: 4'b0000, fall: 4'b1001};
        vecs[2] = '{src: 4'b1011, rise: 4'b1001, fall: 4'b0000};
        vecs[3] = '{src: 4'b0101, rise: 4'b0100, fall: 4'b1010};
        vecs[4] = '{src: 4'b1111, rise: 4'b1010, fall: 4'b0000};
        vecs[5] = '{src: 4'b0000, rise: 4'b0000, fall: 4'b1111};
        vecs[6] = '{src: 4'b1001, rise: 4'b1001, fall: 4'b0000};
        vecs[7] = '{src: 4'b0110, rise: 4'b0110, fall: 4'b1001};

        // Reset with source already at the reset value: no pulse ever.
        rst_n = 1'b0;
        src   = 4'b1010;
        tick(3);
        chk("a_reset_data", a_data, 4'b1010);
        chk("a_reset_pulse", a_rise | a_fall, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        model_en = 1'b1;
        acc = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("a_after_reset_data", a_data, 4'b1010);
            acc = acc | a_rise | a_fall;
        end
        chk("a_after_reset_pulse", acc, 4'b0000);

        // Table: FILT_LEN=0, NSTAGES=2 -> output follows 3 edges after the change.
        prev = 4'b1010;
        for (int v = 0; v < 8; v++) begin
            src = vecs[v].src;
            tick(2);
            chk("a_vec_hold", a_data, prev);
            tick(1);
            chk("a_vec_data", a_data, vecs[v].src);
            chk("a_vec_rise", a_rise, vecs[v].rise);
            chk("a_vec_fall", a_fall, vecs[v].fall);
            chk("a_vec_edge", a_edge, vecs[v].rise | vecs[v].fall);
            tick(1);
            chk("a_vec_pulse_end", a_rise | a_fall, 4'b0000);
            prev = vecs[v].src;
        end

        rst_n = 1'b0;
        src   = 4'b0000;
        tick(2);
        rst_n = 1'b1;
        tick(12);
        chk("b_idle_data", b_data, 4'b0000);

        // Short pulse (3 cycles) against FILT_LEN=4 is swallowed.
        src = 4'b0010;
        tick(3);
        src = 4'b0000;
        acc = 4'b0000;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            acc = acc | b_data | b_rise | b_fall;
        end
        chk("b_short_pulse", acc, 4'b0000);

        // 8-cycle pulse passes: rise after 7 edges, fall 7 edges after the drop.
        src = 4'b0010;
        tick(6);
        chk("b_long_hold", b_data, 4'b0000);
        tick(1);
        chk("b_long_rise_data", b_data, 4'b0010);
        chk("b_long_rise", b_rise, 4'b0010);
        chk("b_long_rise_nofall", b_fall, 4'b0000);
        tick(1);
        chk("b_long_rise_end", b_rise, 4'b0000);
        src = 4'b0000;
        tick(6);
        chk("b_long_fall_hold", b_data, 4'b0010);
        tick(1);
        chk("b_long_fall_data", b_data, 4'b0000);
        chk("b_long_fall", b_fall, 4'b0010);
        chk("b_long_fall_norise", b_rise, 4'b0000);
        tick(12);

        // Abort: 1,1,1,0,1,1,1,1 -> update only after the last run of four.
        src = 4'b0010;
        tick(3);
        src = 4'b0000;
        tick(1);
        src = 4'b0010;
        tick(6);
        chk("b_abort_hold", b_data, 4'b0000);
        tick(1);
        chk("b_abort_data", b_data, 4'b0010);
        chk("b_abort_rise", b_rise, 4'b0010);
        src = 4'b0000;
        tick(12);

        // Reset mid-count on the FILT_LEN=8 instance.
        src = 4'b0011;
        tick(14);
        chk("c_pre_data", c_data, 4'b0011);
        src = 4'b0001;
        tick(7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("c_async_reset_data", c_data, 4'b0000);
        chk("c_async_reset_pulse", c_rise | c_fall, 4'b0000);
        tick(2);
        #2;
        rst_n = 1'b1;
        tick(9);
        chk("c_restart_hold", c_data, 4'b0000);
        tick(1);
        chk("c_restart_data", c_data, 4'b0001);
        chk("c_restart_rise", c_rise, 4'b0001);

        // Randomised source with sub-cycle jitter, checked by the model.
        for (int it = 0; it < 400; it++) begin
            repeat ($urandom_range(1, 12)) @(posedge clk);
            #($urandom_range(1, 8));
            src = src ^ 4'($urandom_range(0, 15));
        end
        tick(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
